// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive bit controller: FSM states,
// line-state encodings ({D+, D-}) and the SYNC pattern.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // NRZI: an unchanged level means 1, a change means 0.
    function automatic logic nrzi_bit(input logic cur, input logic prev);
        return ~(cur ^ prev);
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Free-running bit-period counter with edge reload; strobes at mid-bit.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run_i,
    input  logic reload_i,
    output logic sample_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;

    // Count 0..CLKS_PER_BIT-1; held at zero while idle, zeroed on a line edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= CNT_W'(0);
        end else if (!run_i || reload_i) begin
            cnt_q <= CNT_W'(0);
        end else if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_q <= CNT_W'(0);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign sample_o = run_i && (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));

endmodule

// File: rtl/usb_rx_bit_ctrl.sv
// USB full/low-speed receive bit controller: SYNC detect, NRZI decode,
// bit-unstuffing, byte assembly and EOP/error tracking.
module usb_rx_bit_ctrl
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       rcving,
    output logic       eop,
    output logic       rx_error
);

    state_t     state_q;
    logic       dp_prev_q;
    logic       prev_smp_q;
    logic [2:0] ones_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       eop_ph_q;
    logic [7:0] rx_data_q;
    logic       byte_valid_q;
    logic       rcving_q;
    logic       eop_q;
    logic       rx_error_q;

    logic [1:0] line_s;
    logic       dp_edge_s;
    logic       run_s;
    logic       sample_s;
    logic       bit_s;
    logic       stuff_s;
    logic [7:0] shift_nx_s;

    // Line decode and next-shift value derived from the current sample.
    always_comb begin
        line_s     = {d_plus_sync, d_minus_sync};
        dp_edge_s  = d_plus_sync ^ dp_prev_q;
        run_s      = (state_q != ST_IDLE);
        bit_s      = nrzi_bit(d_plus_sync, prev_smp_q);
        stuff_s    = (ones_q == 3'd6);
        shift_nx_s = {bit_s, shift_q[7:1]};
    end

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .run_i    (run_s),
        .reload_i (dp_edge_s),
        .sample_o (sample_s)
    );

    // Receive FSM with registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            dp_prev_q    <= 1'b1;
            prev_smp_q   <= 1'b1;
            ones_q       <= 3'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            eop_ph_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            byte_valid_q <= 1'b0;
            rcving_q     <= 1'b0;
            eop_q        <= 1'b0;
            rx_error_q   <= 1'b0;
        end else begin
            dp_prev_q    <= d_plus_sync;
            byte_valid_q <= 1'b0;
            eop_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dp_prev_q && (line_s == LINE_K)) begin
                        state_q    <= ST_SYNC;
                        rcving_q   <= 1'b1;
                        rx_error_q <= 1'b0;
                        prev_smp_q <= 1'b1;
                        ones_q     <= 3'd0;
                        bit_cnt_q  <= 3'd0;
                        shift_q    <= 8'h00;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (sample_s) begin
                        if (line_s == LINE_SE1) begin
                            state_q <= ST_ERR;
                        end else if (line_s == LINE_SE0) begin
                            if ((state_q == ST_DATA) && (bit_cnt_q == 3'd0)) begin
                                state_q  <= ST_EOP;
                                eop_ph_q <= 1'b0;
                            end else begin
                                state_q <= ST_ERR;
                            end
                        end else begin
                            prev_smp_q <= d_plus_sync;
                            if (stuff_s) begin
                                // Stuffed bit is dropped; a 1 here is a stuffing violation.
                                if (bit_s) begin
                                    state_q <= ST_ERR;
                                end else begin
                                    ones_q <= 3'd0;
                                end
                            end else begin
                                shift_q   <= shift_nx_s;
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                ones_q    <= bit_s ? (ones_q + 3'd1) : 3'd0;
                                if (bit_cnt_q == 3'd7) begin
                                    if (state_q == ST_SYNC) begin
                                        state_q <= (shift_nx_s == SYNC_PATTERN) ? ST_DATA : ST_ERR;
                                    end else begin
                                        rx_data_q    <= shift_nx_s;
                                        byte_valid_q <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (sample_s) begin
                        if (!eop_ph_q) begin
                            if (line_s == LINE_SE0) begin
                                eop_ph_q <= 1'b1;
                            end else begin
                                state_q <= ST_ERR;
                            end
                        end else if (line_s == LINE_J) begin
                            eop_q    <= 1'b1;
                            rcving_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end
                end
                ST_ERR: begin
                    rx_error_q <= 1'b1;
                    if (sample_s && (line_s == LINE_J)) begin
                        rcving_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign byte_valid = byte_valid_q;
    assign rcving     = rcving_q;
    assign eop        = eop_q;
    assign rx_error   = rx_error_q;

endmodule

// File: doc/usb_rx_bit_ctrl.md
USB_RX_BIT_CTRL -- requirements
Module: usb_rx_bit_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning system clocks per USB bit time; must be even and at least 4.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port d_plus_sync  input  1  synchronized D+ line, idle-high.
REQ-005 SHALL have port d_minus_sync  input  1  synchronized D- line, idle-low.
REQ-006 SHALL have port rx_data  output  8  last completed byte, LSB received first.
REQ-007 SHALL have port byte_valid  output  1  one-cycle pulse when rx_data updates.
REQ-008 SHALL have port rcving  output  1  high while a packet is in progress.
REQ-009 SHALL have port eop  output  1  one-cycle pulse on valid end-of-packet.
REQ-010 SHALL have port rx_error  output  1  sticky packet-error flag.

Function
REQ-011 SHALL decode line states as J = (D+=1, D-=0), K = (D+=0, D-=1) and SE0 = (both 0); the state with both lines 1 SHALL be treated as an error.
REQ-012 SHALL implement FSM states IDLE, SYNC, DATA, EOP and ERR.
REQ-013 SHALL leave IDLE for SYNC, and set rcving, on the first J->K transition of d_plus_sync.
REQ-014 SHALL run a bit timer that counts 0..CLKS_PER_BIT-1 and wraps.
REQ-015 SHALL reload the bit timer to 0 on every d_plus_sync transition while not in IDLE, to resynchronize.
REQ-016 SHALL sample the line when the bit timer equals CLKS_PER_BIT/2-1, and only at that point.
REQ-017 SHALL NRZI-decode each sample: bit = 1 if the sampled D+ equals the previous sample, else 0; the previous sample SHALL be J (1) on entry to SYNC.
REQ-018 SHALL discard the bit that follows six consecutive decoded 1s (bit-stuff removal).
REQ-019 SHALL go to ERR if that stuffed bit decodes as 1.
REQ-020 SHALL reset the consecutive-ones count on any decoded 0 and on any stuffed bit.
REQ-021 SHALL shift decoded bits LSB-first into an 8-bit register.
REQ-022 SHALL, in SYNC, compare the first 8 bits with 8'h80: match -> DATA; mismatch -> ERR.
REQ-023 SHALL, in DATA, copy the shift register to rx_data and pulse byte_valid exactly one cycle after each 8th unstuffed bit.
REQ-024 SHALL go to EOP when SE0 is sampled with bit count = 0; SE0 with bit count 1..7 SHALL go to ERR.
REQ-025 SHALL, in EOP, pulse eop, clear rcving and return to IDLE if the next sample is SE0 and the sample after it is J; any other sequence SHALL go to ERR.
REQ-026 SHALL, in ERR, hold rx_error high and stay there until J is sampled, then clear rcving and return to IDLE.
REQ-027 SHALL clear rx_error on the next IDLE->SYNC transition.
REQ-028 SHALL give priority to the error transition when an edge-resync and a sample point coincide with an error condition in the same cycle.
REQ-029 SHALL never pulse byte_valid in SYNC, EOP or ERR.
REQ-030 SHALL hold rx_data between updates.

Reset
REQ-031 SHALL, on n_rst low, immediately force state IDLE, rx_data=8'h00, byte_valid=0, rcving=0, eop=0 and rx_error=0.
REQ-032 SHALL also reset the bit timer to 0, the previous sample to 1 and the ones count to 0.
REQ-033 SHALL abort any packet in progress on a reset mid-packet, with no byte_valid or eop pulse.

Structure
REQ-034 SHALL place the state enum, the J/K/SE0 encodings and the SYNC_PATTERN (8'h80) constant in shared package usb_rx_pkg.
REQ-035 SHALL implement the bit timer, with reload input and sample-strobe output, as sub-module usb_bit_timer.
REQ-036 SHALL keep the NRZI, unstuff and shift logic in the top module.

Verification
REQ-037 Send SYNC, then byte 8'hA5, then SE0,SE0,J -> byte_valid once with rx_data=8'hA5, eop pulse, rcving low, rx_error=0.
REQ-038 Send SYNC, 8'hFF (stuffed 0 inserted), then EOP -> rx_data=8'hFF with no error; repeat with the stuffed bit sent as 1 -> rx_error=1, no byte_valid.
REQ-039 Send a corrupted SYNC 8'h81 -> ERR, rx_error=1, no byte_valid; a following good packet -> rx_error cleared and correct byte.
REQ-040 Send SE0 after 4 data bits -> rx_error=1; J restores IDLE with rcving=0.
REQ-041 Apply line jitter of ±1 clock per bit edge over a 3-byte packet -> all bytes correct.
REQ-042 Assert n_rst mid-byte -> all outputs at reset values within the same cycle, no pulses, and the next packet is received correctly.
